// File: rtl/audio_tone_meter_if.sv
// rtl/audio_tone_meter_if.sv - sample stream and measurement results bundle for audio_tone_meter
//
// Purpose: groups the sample strobe/data and the per-cycle measurement outputs
//          so a source/checker and the meter connect with one port.
// Signals:
//   clk_ena    sample strobe, audio valid when high          (master -> slave)
//   audio      signed 16-bit sample                           (master -> slave)
//   period     last measured period in samples, PERIOD_W bits (slave -> master)
//   peak_pos   maximum sample of last measured cycle          (slave -> master)
//   peak_neg   minimum sample of last measured cycle          (slave -> master)
//   cycle_done one-clk pulse when period/peaks update         (slave -> master)
//   locked     consecutive in-tolerance periods seen          (slave -> master)
//   timeout    no rising crossing within the period range     (slave -> master)
// PERIOD_W must match the PERIOD_W of the audio_tone_meter it connects to.

interface audio_tone_meter_if #(
   parameter int PERIOD_W = 10
);
   logic                       clk_ena;
   logic signed [15:0]         audio;
   logic        [PERIOD_W-1:0] period;
   logic signed [15:0]         peak_pos;
   logic signed [15:0]         peak_neg;
   logic                       cycle_done;
   logic                       locked;
   logic                       timeout;

   modport master (
      output clk_ena, audio,
      input  period, peak_pos, peak_neg, cycle_done, locked, timeout
   );

   modport slave (
      input  clk_ena, audio,
      output period, peak_pos, peak_neg, cycle_done, locked, timeout
   );
endinterface

// File: rtl/audio_tone_meter.sv
// rtl/audio_tone_meter.sv - tone period/peak analyser with lock and timeout detection
//
// Purpose: measures, per tone cycle, the period in samples between rising zero
//          crossings plus the positive/negative peaks, and declares lock after
//          LOCK_COUNT consecutive periods within TOLERANCE of EXPECT_PERIOD.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      audio_tone_meter_if.slave: clk_ena/audio in; period, peak_pos,
//            peak_neg, cycle_done, locked, timeout out (all registered)

module audio_tone_meter #(
   parameter int PERIOD_W      = 10,
   parameter int EXPECT_PERIOD = 48,
   parameter int TOLERANCE     = 1,
   parameter int LOCK_COUNT    = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   audio_tone_meter_if.slave bus
);

   localparam logic [PERIOD_W-1:0] MAX_PERIOD = '1;
   localparam int                  MC_W       = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam logic [MC_W-1:0]     LOCK_VAL   = MC_W'(LOCK_COUNT);
   localparam logic [PERIOD_W:0]   EXP_EXT    = (PERIOD_W + 1)'(EXPECT_PERIOD);
   localparam logic [PERIOD_W:0]   TOL_EXT    = (PERIOD_W + 1)'(TOLERANCE);

   typedef enum logic {SEARCH, MEASURE} state_t;

   state_t                    state;
   logic signed [15:0]        prev;
   logic                      prev_valid;
   logic        [PERIOD_W-1:0] cnt;
   logic signed [15:0]        run_max;
   logic signed [15:0]        run_min;
   logic        [MC_W-1:0]    match_cnt;

   logic        [PERIOD_W-1:0] period_q;
   logic signed [15:0]        peak_pos_q;
   logic signed [15:0]        peak_neg_q;
   logic                      cycle_done_q;
   logic                      locked_q;
   logic                      timeout_q;

   logic                      xing;
   logic signed [15:0]        run_max_nxt;
   logic signed [15:0]        run_min_nxt;
   logic        [PERIOD_W:0]  cnt_ext;
   logic        [PERIOD_W:0]  diff;
   logic                      match;
   logic        [MC_W-1:0]    match_cnt_nxt;

   // Sign bits suffice: prev < 0 and audio >= 0.
   assign xing = prev_valid & prev[15] & ~bus.audio[15];

   always_comb begin
      run_max_nxt   = (bus.audio > run_max) ? bus.audio : run_max;
      run_min_nxt   = (bus.audio < run_min) ? bus.audio : run_min;
      // Absolute deviation taken one bit wider so the subtraction never wraps.
      cnt_ext       = {1'b0, cnt};
      diff          = (cnt_ext >= EXP_EXT) ? (cnt_ext - EXP_EXT) : (EXP_EXT - cnt_ext);
      match         = (diff <= TOL_EXT);
      match_cnt_nxt = (match_cnt == LOCK_VAL) ? match_cnt : (match_cnt + 1'b1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= SEARCH;
         prev         <= '0;
         prev_valid   <= 1'b0;
         cnt          <= '0;
         run_max      <= '0;
         run_min      <= '0;
         match_cnt    <= '0;
         period_q     <= '0;
         peak_pos_q   <= '0;
         peak_neg_q   <= '0;
         cycle_done_q <= 1'b0;
         locked_q     <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         // Pulse lasts one clk regardless of strobe spacing.
         cycle_done_q <= 1'b0;
         if (bus.clk_ena) begin
            prev       <= bus.audio;
            prev_valid <= 1'b1;
            if (xing) begin
               // The crossing sample opens the next cycle; it is not part of
               // the cycle being reported.
               cnt     <= PERIOD_W'(1);
               run_max <= bus.audio;
               run_min <= bus.audio;
               if (state == SEARCH) begin
                  state <= MEASURE;
               end else begin
                  period_q     <= cnt;
                  peak_pos_q   <= run_max;
                  peak_neg_q   <= run_min;
                  cycle_done_q <= 1'b1;
                  timeout_q    <= 1'b0;
                  if (match) begin
                     match_cnt <= match_cnt_nxt;
                     locked_q  <= (match_cnt_nxt == LOCK_VAL);
                  end else begin
                     match_cnt <= '0;
                     locked_q  <= 1'b0;
                  end
               end
            end else begin
               run_max <= run_max_nxt;
               run_min <= run_min_nxt;
               if (cnt != MAX_PERIOD) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  // Counter saturated with no crossing: tone is gone.
                  timeout_q <= 1'b1;
                  locked_q  <= 1'b0;
                  match_cnt <= '0;
                  state     <= SEARCH;
               end
            end
         end
      end
   end

   assign bus.period     = period_q;
   assign bus.peak_pos   = peak_pos_q;
   assign bus.peak_neg   = peak_neg_q;
   assign bus.cycle_done = cycle_done_q;
   assign bus.locked     = locked_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_audio_tone_meter.sv
// tb/tb_audio_tone_meter.sv - directed self-checking bench for audio_tone_meter

module tb_audio_tone_meter;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   audio_tone_meter_if #(.PERIOD_W(10)) bus ();

   audio_tone_meter #(
      .PERIOD_W(10), .EXPECT_PERIOD(48), .TOLERANCE(1), .LOCK_COUNT(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   int sine_tab[48];

   // Per-cycle_done record, filled by send.
   int n_samp, n_done, n_wide;
   int rec_period[16], rec_pp[16], rec_pn[16], rec_locked[16], rec_k[16];

   task automatic send(input int v, input int gap);
      @(negedge clk);
      bus.clk_ena = 1'b1;
      bus.audio   = 16'(v);
      @(posedge clk);
      #1;
      if (bus.cycle_done && n_done < 16) begin
         rec_period[n_done] = int'(bus.period);
         rec_pp[n_done]     = int'(bus.peak_pos);
         rec_pn[n_done]     = int'(bus.peak_neg);
         rec_locked[n_done] = int'(bus.locked);
         rec_k[n_done]      = n_samp;
      end
      if (bus.cycle_done) n_done++;
      n_samp++;
      bus.clk_ena = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
         if (bus.cycle_done) n_wide++;
      end
   endtask

   task automatic send_cycle(input int len);
      send(0, 0);
      for (int i = 1; i < len; i++)
         send((i <= len / 2) ? len * 10 : -(len * 20), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_samp = 0;
      n_done = 0;
      n_wide = 0;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      bus.clk_ena = 1'b0;
      bus.audio   = '0;
      #2;
      total++;
      if ({bus.period, bus.peak_pos, bus.peak_neg, bus.cycle_done, bus.locked, bus.timeout} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got period=%0d pp=%0d pn=%0d done=%0b lock=%0b to=%0b exp all 0",
                  bus.period, bus.peak_pos, bus.peak_neg, bus.cycle_done, bus.locked, bus.timeout);
      end
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.period, bus.cycle_done, bus.locked, bus.timeout} !== '0) begin
         bad++;
         $display("FAIL reset_hold got period=%0d done=%0b lock=%0b to=%0b exp 0", bus.period,
                  bus.cycle_done, bus.locked, bus.timeout);
      end
   endtask

   task automatic test_sine_lock();
      do_reset();
      for (int k = 0; k <= 240; k++) send(sine_tab[k % 48], 3);
      total++;
      if (n_done != 4) begin bad++; $display("FAIL sine_done_count got=%0d exp=4", n_done); end
      total++;
      if (rec_k[0] != 96) begin bad++; $display("FAIL sine_first_done_sample got=%0d exp=96", rec_k[0]); end
      total++;
      if (rec_period[0] != 48) begin bad++; $display("FAIL sine_period got=%0d exp=48", rec_period[0]); end
      total++;
      if (rec_pp[0] != 32767) begin bad++; $display("FAIL sine_peak_pos got=%0d exp=32767", rec_pp[0]); end
      total++;
      if (rec_pn[0] != -32767) begin bad++; $display("FAIL sine_peak_neg got=%0d exp=-32767", rec_pn[0]); end
      total++;
      if (rec_locked[2] != 0) begin bad++; $display("FAIL sine_lock_early got=%0d exp=0", rec_locked[2]); end
      total++;
      if (rec_locked[3] != 1 || rec_k[3] != 240) begin
         bad++;
         $display("FAIL sine_lock_4th got lock=%0d at=%0d exp lock=1 at=240", rec_locked[3], rec_k[3]);
      end
      total++;
      if (n_wide != 0) begin bad++; $display("FAIL sine_done_width extra_high_clks=%0d exp=0", n_wide); end
   endtask

   task automatic test_alt_periods();
      int lens[10]  = '{48, 47, 49, 47, 49, 50, 48, 48, 48, 48};
      int exp_p[9]  = '{47, 49, 47, 49, 50, 48, 48, 48, 48};
      int exp_l[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
      do_reset();
      for (int c = 0; c < 10; c++) send_cycle(lens[c]);
      send(0, 0);
      total++;
      if (n_done != 9) begin bad++; $display("FAIL alt_done_count got=%0d exp=9", n_done); end
      for (int d = 0; d < 9; d++) begin
         total++;
         if (rec_period[d] != exp_p[d] || rec_locked[d] != exp_l[d]) begin
            bad++;
            $display("FAIL alt_cycle%0d got period=%0d lock=%0d exp period=%0d lock=%0d", d,
                     rec_period[d], rec_locked[d], exp_p[d], exp_l[d]);
         end
      end
      total++;
      if (rec_pp[4] != 500 || rec_pn[4] != -1000) begin
         bad++;
         $display("FAIL alt_peaks50 got pp=%0d pn=%0d exp pp=500 pn=-1000", rec_pp[4], rec_pn[4]);
      end
   endtask

   task automatic test_timeout_dc();
      int early = 0;
      do_reset();
      for (int i = 0; i < 1023; i++) begin
         send(100, 0);
         if (bus.timeout) early++;
      end
      total++;
      if (early != 0) begin bad++; $display("FAIL dc_timeout_early got=%0d exp=0", early); end
      send(100, 0);
      total++;
      if (bus.timeout !== 1'b1 || bus.locked !== 1'b0 || bus.period !== 10'd0 || n_done != 0) begin
         bad++;
         $display("FAIL dc_timeout_1024 got to=%0b lock=%0b period=%0d dones=%0d exp to=1 lock=0 period=0 dones=0",
                  bus.timeout, bus.locked, bus.period, n_done);
      end
      for (int k = 0; k <= 96; k++) begin
         send(sine_tab[k % 48], 0);
         if (k == 48) begin
            total++;
            if (bus.timeout !== 1'b1) begin
               bad++;
               $display("FAIL dc_timeout_first_xing got=%0b exp=1", bus.timeout);
            end
         end
      end
      total++;
      if (bus.timeout !== 1'b0 || n_done != 1 || rec_period[0] != 48) begin
         bad++;
         $display("FAIL dc_timeout_clear got to=%0b dones=%0d period=%0d exp to=0 dones=1 period=48",
                  bus.timeout, n_done, rec_period[0]);
      end
   endtask

   task automatic test_lock_then_dc();
      int early = 0;
      do_reset();
      for (int k = 0; k <= 240; k++) send(sine_tab[k % 48], 0);
      total++;
      if (bus.locked !== 1'b1) begin bad++; $display("FAIL lockdc_locked got=%0b exp=1", bus.locked); end
      for (int n = 1; n <= 1022; n++) begin
         send(-5, 0);
         if (bus.timeout || !bus.locked) early++;
      end
      total++;
      if (early != 0) begin bad++; $display("FAIL lockdc_early_drop got=%0d exp=0", early); end
      send(-5, 0);
      total++;
      if (bus.timeout !== 1'b1 || bus.locked !== 1'b0) begin
         bad++;
         $display("FAIL lockdc_1023 got to=%0b lock=%0b exp to=1 lock=0", bus.timeout, bus.locked);
      end
      total++;
      if (bus.period !== 10'd48 || bus.peak_pos !== 16'sd32767 || bus.peak_neg !== -16'sd32767) begin
         bad++;
         $display("FAIL lockdc_hold got period=%0d pp=%0d pn=%0d exp 48 32767 -32767",
                  bus.period, bus.peak_pos, bus.peak_neg);
      end
   endtask

   task automatic test_boundary();
      int seq[7] = '{-5, -1, 0, 0, 5, -32768, 32767};
      do_reset();
      for (int i = 0; i < 7; i++) send(seq[i], 1);
      total++;
      if (n_done != 1 || rec_k[0] != 6) begin
         bad++;
         $display("FAIL bound_done got dones=%0d at=%0d exp dones=1 at=6", n_done, rec_k[0]);
      end
      total++;
      if (rec_period[0] != 4) begin bad++; $display("FAIL bound_period got=%0d exp=4", rec_period[0]); end
      total++;
      if (rec_pp[0] != 5 || rec_pn[0] != -32768) begin
         bad++;
         $display("FAIL bound_peaks got pp=%0d pn=%0d exp pp=5 pn=-32768", rec_pp[0], rec_pn[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k <= 260; k++) send(sine_tab[k % 48], 3);
      total++;
      if (bus.locked !== 1'b1) begin bad++; $display("FAIL mid_locked_before got=%0b exp=1", bus.locked); end
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      total++;
      if ({bus.period, bus.peak_pos, bus.peak_neg, bus.cycle_done, bus.locked, bus.timeout} !== '0) begin
         bad++;
         $display("FAIL mid_async_clear got period=%0d pp=%0d pn=%0d lock=%0b exp all 0",
                  bus.period, bus.peak_pos, bus.peak_neg, bus.locked);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_samp = 0;
      n_done = 0;
      n_wide = 0;
      for (int k = 0; k <= 240; k++) send(sine_tab[k % 48], $urandom_range(0, 6));
      total++;
      if (n_done != 4 || rec_k[0] != 96 || rec_k[3] != 240) begin
         bad++;
         $display("FAIL mid_relock_timing got dones=%0d first=%0d fourth=%0d exp 4 96 240",
                  n_done, rec_k[0], rec_k[3]);
      end
      total++;
      if (rec_period[0] != 48 || rec_pp[0] != 32767 || rec_pn[0] != -32767) begin
         bad++;
         $display("FAIL mid_relock_values got period=%0d pp=%0d pn=%0d exp 48 32767 -32767",
                  rec_period[0], rec_pp[0], rec_pn[0]);
      end
      total++;
      if (rec_locked[2] != 0 || rec_locked[3] != 1) begin
         bad++;
         $display("FAIL mid_relock_lock got third=%0d fourth=%0d exp 0 1", rec_locked[2], rec_locked[3]);
      end
   endtask

   initial begin
      for (int i = 0; i < 48; i++)
         sine_tab[i] = int'($floor(32767.0 * $sin(2.0 * 3.141592653589793 * i / 48.0)));
      n_samp = 0;
      n_done = 0;
      n_wide = 0;
      test_reset();
      test_sine_lock();
      test_alt_periods();
      test_timeout_dc();
      test_lock_then_dc();
      test_boundary();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
